// File: rtl/serial_divider_7_restoring.sv
// Bit-serial restoring divider: a 2*width-bit dividend by a width-bit divisor, one quotient bit per clock.
// It uses the same en/valid handshake as the serial shift-add multiplier.
module serial_divider_7_restoring #(
   parameter int width = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [2*width-1:0] N,
   input  logic [width-1:0]   D,
   output logic               valid,
   output logic [2*width-1:0] Q,
   output logic [width-1:0]   R,
   output logic               dz
);

   localparam int CNT_W = $clog2(2*width+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [width:0]     rem;
   logic [2*width-1:0] sreg;
   logic [width-1:0]   dreg;
   logic               zpend;

   logic [width:0]        rem_sh;
   logic signed [width:0] t;
   logic                  qbit;
   logic [width:0]        rem_nx;
   logic [2*width-1:0]    sreg_nx;

   // The partial remainder stays below 2*D, so rem_sh - D always fits in width+1 signed bits.
   always_comb begin
      rem_sh  = {rem[width-1:0], sreg[2*width-1]};
      t       = $signed(rem_sh) - $signed({1'b0, dreg});
      qbit    = ~t[width];
      rem_nx  = qbit ? $unsigned(t) : rem_sh;
      sreg_nx = {sreg[2*width-2:0], qbit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         sreg  <= '0;
         dreg  <= '0;
         zpend <= 1'b0;
         valid <= 1'b0;
         Q     <= '0;
         R     <= '0;
         dz    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (en) begin
                  dreg  <= D;
                  sreg  <= N;
                  rem   <= '0;
                  valid <= 1'b0;
                  dz    <= 1'b0;
                  if (D != '0) begin
                     state <= BUSY;
                     cnt   <= CNT_W'(2*width);
                     zpend <= 1'b0;
                  end else begin
                     state <= DONE;
                     cnt   <= '0;
                     zpend <= 1'b1;
                  end
               end else if (zpend) begin
                  // A zero divisor reports its result one edge after acceptance.
                  valid <= 1'b1;
                  dz    <= 1'b1;
                  Q     <= '1;
                  R     <= sreg[width-1:0];
                  zpend <= 1'b0;
               end
            end
            BUSY: begin
               sreg <= sreg_nx;
               rem  <= rem_nx;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  Q     <= sreg_nx;
                  R     <= rem_nx[width-1:0];
                  valid <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_divider_7_restoring.sv
// Testbench for serial_divider_7_restoring: directed cases plus a random regression.
// Results are checked against plain division and modulo arithmetic.
module tb_serial_divider_7_restoring;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [13:0] N;
   logic [6:0]  D;
   logic        valid;
   logic [13:0] Q;
   logic [6:0]  R;
   logic        dz;

   int n_assert;
   int n_fail;

   serial_divider_7_restoring #(.width(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .N     (N),
      .D     (D),
      .valid (valid),
      .Q     (Q),
      .R     (R),
      .dz    (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one start pulse, then scramble the operand inputs to show only latched copies matter.
   task automatic start_op(input logic [13:0] n, input logic [6:0] d);
      @(negedge clk);
      N  = n;
      D  = d;
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      N  = 14'($urandom);
      D  = 7'($urandom);
      chk("accept_valid_clr", valid, 0);
   endtask

   task automatic wait_result(input logic [13:0] n, input logic [6:0] d, input int edges0);
      int          edges;
      int          lat;
      logic [13:0] qx;
      logic [6:0]  rx;
      logic        dzx;
      edges = edges0;
      if (d == 0) begin
         lat = 1;
         qx  = 14'h3fff;
         rx  = n[6:0];
         dzx = 1'b1;
      end else begin
         lat = 14;
         qx  = 14'(n / d);
         rx  = 7'(n % d);
         dzx = 1'b0;
      end
      while (!valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk($sformatf("latency %0d/%0d", n, d), edges, lat);
      chk($sformatf("valid %0d/%0d", n, d), valid, 1);
      chk($sformatf("Q %0d/%0d", n, d), Q, qx);
      chk($sformatf("R %0d/%0d", n, d), R, rx);
      chk($sformatf("dz %0d/%0d", n, d), dz, dzx);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      N        = '0;
      D        = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_Q", Q, 0);
      chk("rst_R", R, 0);
      chk("rst_dz", dz, 0);
      #2 rst_n = 1'b1;

      start_op(14'd100, 7'd7);
      wait_result(14'd100, 7'd7, 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", valid, 1);
         chk("hold_Q", Q, 14);
         chk("hold_R", R, 2);
      end

      start_op(14'd16383, 7'd127);
      wait_result(14'd16383, 7'd127, 0);
      chk("Q_16383_127", Q, 129);
      start_op(14'd16383, 7'd1);
      wait_result(14'd16383, 7'd1, 0);
      start_op(14'd3, 7'd100);
      wait_result(14'd3, 7'd100, 0);
      start_op(14'd0, 7'd5);
      wait_result(14'd0, 7'd5, 0);

      start_op(14'd5, 7'd0);
      wait_result(14'd5, 7'd0, 0);
      chk("dz_Q_ones", Q, 16383);
      start_op(14'd9, 7'd3);
      wait_result(14'd9, 7'd3, 0);

      // A second start pulse while busy must be ignored.
      start_op(14'd100, 7'd7);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      N  = 14'd50;
      D  = 7'd5;
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      chk("busy_en_valid", valid, 0);
      wait_result(14'd100, 7'd7, 6);

      start_op(14'd200, 7'd9);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid", valid, 0);
      chk("midrst_Q", Q, 0);
      chk("midrst_R", R, 0);
      chk("midrst_dz", dz, 0);
      #10 rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         chk("postrst_valid", valid, 0);
      end
      start_op(14'd200, 7'd9);
      wait_result(14'd200, 7'd9, 0);

      for (int i = 0; i < 50; i++) begin
         logic [6:0]  a;
         logic [6:0]  b;
         logic [13:0] p;
         a = 7'($urandom_range(0, 127));
         b = 7'($urandom_range(1, 127));
         p = 14'(a * b);
         start_op(p, b);
         wait_result(p, b, 0);
         chk("rand_Q_eq_A", Q, a);
         chk("rand_R_zero", R, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
